// File: rtl/grf_wb_pkg.sv
// ============================================================================
//  Module      : grf_wb_pkg
//  Description : Shared widths and the queued-write entry type for the GRF
//                write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grf_wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // One queued mult/div result; valid drops when a younger pipe write kills it
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/grf_write_arbiter_if.sv
// ============================================================================
//  Module      : grf_write_arbiter_if
//  Description : Bundle of pipe W-stage, mult/div, decode-check and GRF write
//                signals around the write arbiter. slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grf_write_arbiter_if #(
    parameter int DEPTH = 4
);
    import grf_wb_pkg::*;

    logic                  pipe_we;
    logic [REG_AW-1:0]     pipe_wa;
    logic [DATA_W-1:0]     pipe_wd;
    logic [DATA_W-1:0]     pipe_pc;
    logic                  md_valid;
    logic                  md_ready;
    logic [REG_AW-1:0]     md_wa;
    logic [DATA_W-1:0]     md_wd;
    logic [DATA_W-1:0]     md_pc;
    logic [REG_AW-1:0]     ra1;
    logic [REG_AW-1:0]     ra2;
    logic                  busy1;
    logic                  busy2;
    logic [$clog2(DEPTH):0] pending;
    logic                  RegWrite;
    logic [REG_AW-1:0]     WA;
    logic [DATA_W-1:0]     WD;
    logic [DATA_W-1:0]     PC;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, pipe_pc,
        input  md_valid, md_wa, md_wd, md_pc,
        input  ra1, ra2,
        output md_ready, busy1, busy2, pending,
        output RegWrite, WA, WD, PC
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd, pipe_pc,
        output md_valid, md_wa, md_wd, md_pc,
        output ra1, ra2,
        input  md_ready, busy1, busy2, pending,
        input  RegWrite, WA, WD, PC
    );

endinterface

`default_nettype wire

// File: rtl/grf_wb_fifo.sv
// ============================================================================
//  Module      : grf_wb_fifo
//  Description : DEPTH-entry circular queue of mult/div results with per-entry
//                valid, kill-by-address and live-entry address lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   i_push,
    input  wire wb_entry_t              i_push_entry,
    input  wire logic                   i_pop,
    input  wire logic                   i_kill_en,
    input  wire logic [REG_AW-1:0]      i_kill_wa,
    input  wire logic [REG_AW-1:0]      i_ra1,
    input  wire logic [REG_AW-1:0]      i_ra2,
    output logic                        o_busy1,
    output logic                        o_busy2,
    output wb_entry_t                   o_head,
    output logic                        o_empty,
    output logic                        o_full,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

    // Queue storage: kill matching entries, retire head, append at tail.
    // A popped slot has its valid cleared so valid always implies occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_mem[i].valid && (r_mem[i].wa == i_kill_wa)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (i_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Decode hazard lookup over live entries only; $0 is never busy
    always_comb begin
        o_busy1 = 1'b0;
        o_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].valid && (r_mem[i].wa == i_ra1) && (i_ra1 != '0)) o_busy1 = 1'b1;
            if (r_mem[i].valid && (r_mem[i].wa == i_ra2) && (i_ra2 != '0)) o_busy2 = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/grf_write_arbiter.sv
// ============================================================================
//  Module      : grf_write_arbiter
//  Description : Merges W-stage writes and queued mult/div results onto the
//                single registered GRF write port. Pipe has priority; queued
//                results fill idle slots and are killed by younger pipe writes.
//                Optional macro WB_TRACE_EN prints each committed write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_write_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    grf_write_arbiter_if.slave bus
);

    logic              w_pipe_live;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    wb_entry_t         w_head;
    wb_entry_t         w_push_entry;

    logic              r_regwrite;
    logic [REG_AW-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic [DATA_W-1:0] r_pc;

    // A write to $0 is treated as an idle slot
    assign w_pipe_live = bus.pipe_we && (bus.pipe_wa != '0);

    // Accepted results for $0, or for a register the concurrent pipe write
    // overwrites, complete the handshake but are never stored
    assign bus.md_ready = !w_full;
    assign w_push = bus.md_valid && !w_full && (bus.md_wa != '0) &&
                    !(w_pipe_live && (bus.md_wa == bus.pipe_wa));
    assign w_push_entry = '{valid: 1'b1, wa: bus.md_wa, wd: bus.md_wd, pc: bus.md_pc};

    // Killed heads drain without using the port; live heads need an idle slot
    assign w_pop = !w_empty && (!w_head.valid || !w_pipe_live);

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_pipe_live),
        .i_kill_wa    (bus.pipe_wa),
        .i_ra1        (bus.ra1),
        .i_ra2        (bus.ra2),
        .o_busy1      (bus.busy1),
        .o_busy2      (bus.busy2),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_count      (bus.pending)
    );

    // GRF port register: pipe first, then a live queue head, else no write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_pc       <= '0;
        end else if (w_pipe_live) begin
            r_regwrite <= 1'b1;
            r_wa       <= bus.pipe_wa;
            r_wd       <= bus.pipe_wd;
            r_pc       <= bus.pipe_pc;
        end else if (!w_empty && w_head.valid) begin
            r_regwrite <= 1'b1;
            r_wa       <= w_head.wa;
            r_wd       <= w_head.wd;
            r_pc       <= w_head.pc;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign bus.RegWrite = r_regwrite;
    assign bus.WA       = r_wa;
    assign bus.WD       = r_wd;
    assign bus.PC       = r_pc;

`ifdef WB_TRACE_EN
    // Commit trace, one line per GRF write
    always_ff @(posedge clk) begin
        if (r_regwrite) $display("@%h: $%d <= %h", r_pc, r_wa, r_wd);
    end
`else
    // No commit trace in this build
`endif

endmodule

`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
// ============================================================================
//  Module      : tb_grf_write_arbiter
//  Description : Scoreboard bench for grf_write_arbiter against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grf_write_arbiter;
    import grf_wb_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        bit          live;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } m_ent_t;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    m_ent_t mq[$];
    exp_t   exp_q[$];

    always #5 clk = ~clk;

    grf_write_arbiter_if #(.DEPTH(DEPTH)) bus();

    grf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: drive inputs, check status vs model, advance model, queue expectation
    task automatic step(input bit pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                        input bit mv, input logic [4:0] mwa, input logic [31:0] mwd,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        bit   plive;
        bit   full;
        logic [31:0] ppc;
        logic [31:0] mpc;
        ppc = $urandom;
        mpc = $urandom;
        @(negedge clk);
        bus.pipe_we = pwe; bus.pipe_wa = pwa; bus.pipe_wd = pwd; bus.pipe_pc = ppc;
        bus.md_valid = mv; bus.md_wa = mwa; bus.md_wd = mwd; bus.md_pc = mpc;
        bus.ra1 = a1; bus.ra2 = a2;
        #1;
        full = (mq.size() >= DEPTH);
        chk("md_ready", 32'(bus.md_ready), 32'(!full));
        chk("pending", 32'(bus.pending), 32'(mq.size()));
        chk("busy1", 32'(bus.busy1), 32'(m_busy(a1)));
        chk("busy2", 32'(bus.busy2), 32'(m_busy(a2)));
        plive = pwe && (pwa != 5'd0);
        e = '{we: 1'b0, wa: 5'd0, wd: 32'd0, pc: 32'd0};
        if (plive) e = '{we: 1'b1, wa: pwa, wd: pwd, pc: ppc};
        if (mq.size() > 0) begin
            if (!mq[0].live) begin
                void'(mq.pop_front());
            end else if (!plive) begin
                e = '{we: 1'b1, wa: mq[0].wa, wd: mq[0].wd, pc: mq[0].pc};
                void'(mq.pop_front());
            end
        end
        if (plive) foreach (mq[i]) if (mq[i].wa == pwa) mq[i].live = 1'b0;
        if (mv && !full && mwa != 5'd0 && !(plive && mwa == pwa))
            mq.push_back('{live: 1'b1, wa: mwa, wd: mwd, pc: mpc});
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one GRF slot per clock; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RegWrite", 32'(bus.RegWrite), 32'(e.we));
                if (e.we) begin
                    chk("WA", 32'(bus.WA), 32'(e.wa));
                    chk("WD", bus.WD, e.wd);
                    chk("PC", bus.PC, e.pc);
                end
            end
        end
    end

    initial begin
        bus.pipe_we = 0; bus.pipe_wa = 0; bus.pipe_wd = 0; bus.pipe_pc = 0;
        bus.md_valid = 0; bus.md_wa = 0; bus.md_wd = 0; bus.md_pc = 0;
        bus.ra1 = 0; bus.ra2 = 0;
        reset = 1'b1;
        #1;
        chk("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Pipe write passes with latency 1
        step(1, 3, 32'h11, 0, 0, 0, 0, 0);
        idle(2);
        // md result, pipe idle; busy seen in between
        step(0, 0, 0, 1, 8, 32'hABCD, 8, 0);
        step(0, 0, 0, 0, 0, 0, 8, 8);
        idle(2);
        // Fill queue under constant pipe traffic, then drain in order
        for (int i = 0; i < 5; i++)
            step(1, 5'(20 + i), $urandom, 1, 5'(1 + i), $urandom, 5'(1 + i), 5'(2 + i));
        idle(6);
        // Kill a queued entry
        step(0, 0, 0, 1, 5, 32'h55, 0, 0);
        step(1, 6, 32'h66, 1, 7, 32'h77, 5, 7);
        step(1, 5, 32'h7, 0, 0, 0, 5, 7);
        step(0, 0, 0, 0, 0, 0, 5, 7);
        idle(3);
        // md and pipe to the same register in one cycle
        step(1, 9, 32'h99, 1, 9, 32'h1234, 9, 0);
        idle(2);

        // Randomized traffic with alternating busy/idle pipe phases
        for (int c = 0; c < 1500; c++) begin
            int pw;
            pw = ((c / 40) % 3 == 0) ? 90 : ((c / 40) % 3 == 1) ? 20 : 55;
            step(($urandom_range(0, 99) < pw), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(1, 5'(20 + i), $urandom, 1, 5'(10 + i), $urandom, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("arst_WA", 32'(bus.WA), 32'd0);
        chk("arst_WD", bus.WD, 32'd0);
        chk("arst_PC", bus.PC, 32'd0);
        chk("arst_pending", 32'(bus.pending), 32'd0);
        chk("arst_md_ready", 32'(bus.md_ready), 32'd1);
        exp_q.delete();
        mq.delete();
        bus.pipe_we = 0; bus.md_valid = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(6);
        @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
